// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package if_fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DROP,
    S_FAULT
  } if_state_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory handshake plus the IF -> IF/ID bundle driven by the fetch controller.
interface if_fetch_ctrl_if;
  import if_fetch_ctrl_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  logic [XLEN-1:0] PCOut;
  logic [XLEN-1:0] PCAdd4;
  logic [XLEN-1:0] IF_Instruction;
  logic            IF_Stall;
  logic            IF_Flush;
  logic            IF_AdEL;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output PCOut, PCAdd4, IF_Instruction, IF_Stall, IF_Flush, IF_AdEL
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  PCOut, PCAdd4, IF_Instruction, IF_Stall, IF_Flush, IF_AdEL
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, issues imem requests, absorbs latency, back-pressure and redirects.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ID_Stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  if_fetch_ctrl_if.master bus
);

  if_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_hold;
  logic [XLEN-1:0] r_drop;

  if_state_t       w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_hold_nxt;
  logic [XLEN-1:0] w_drop_nxt;
  logic            w_req;
  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_instr;
  logic            w_flush;
  logic            w_stall;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_VECTOR;
      r_hold  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hold  <= w_hold_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold;
    w_drop_nxt  = r_drop;
    w_req       = 1'b0;
    w_addr      = r_pc;
    w_instr     = '0;
    w_flush     = !ID_Stall;
    w_stall     = ID_Stall;

    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (bus.imem_ready) begin
          w_instr = bus.imem_rdata;
          w_flush = 1'b0;
          if (!ID_Stall) begin
            w_pc_nxt = r_pc + XLEN'(4);
          end else begin
            w_hold_nxt  = bus.imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        w_instr = r_hold;
        w_flush = 1'b0;
        if (!ID_Stall) begin
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = S_FETCH;
        end
      end
      S_DROP: begin
        // Stale response for the pre-redirect address is swallowed here.
        w_req  = 1'b1;
        w_addr = r_drop;
        if (bus.imem_ready) begin
          w_state_nxt = is_misaligned(r_pc) ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: begin
        w_req = 1'b0;
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Redirect overrides everything; an in-flight request must drain before refetching.
    if (redirect_valid) begin
      w_pc_nxt   = redirect_pc;
      w_hold_nxt = r_hold;
      w_instr    = '0;
      w_flush    = 1'b1;
      w_stall    = 1'b0;
      if (r_state == S_FETCH && !bus.imem_ready) begin
        w_drop_nxt  = r_pc;
        w_state_nxt = S_DROP;
      end else if (r_state == S_DROP && !bus.imem_ready) begin
        w_state_nxt = S_DROP;
      end else begin
        w_state_nxt = is_misaligned(redirect_pc) ? S_FAULT : S_FETCH;
      end
    end

    if (!reset_n) begin
      w_req   = 1'b0;
      w_instr = '0;
      w_flush = 1'b1;
      w_stall = 1'b0;
    end
  end

  assign bus.imem_req       = w_req;
  assign bus.imem_addr      = w_addr;
  assign bus.PCOut          = r_pc;
  assign bus.PCAdd4         = r_pc + XLEN'(4);
  assign bus.IF_Instruction = w_instr;
  assign bus.IF_Stall       = w_stall;
  assign bus.IF_Flush       = w_flush;
  assign bus.IF_AdEL        = (r_state == S_FAULT);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized run against a stream model.
module tb_if_fetch_ctrl;

  logic        clock;
  logic        reset_n;
  logic        ID_Stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;
  bit mem_rand = 1'b0;
  int mem_cnt  = 0;

  if_fetch_ctrl_if u_if ();

  if_fetch_ctrl #(.RESET_VECTOR(32'hBFC0_0000)) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ID_Stall       (ID_Stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (u_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: fixed wait-state count, or random readiness.
  always @(negedge clock) begin
    if (!reset_n) begin
      u_if.imem_ready <= 1'b0;
      u_if.imem_rdata <= '0;
      mem_cnt         <= 0;
    end else if (u_if.imem_req) begin
      if (mem_rand ? ($urandom_range(0, 2) == 0) : (mem_cnt >= mem_lat)) begin
        u_if.imem_ready <= 1'b1;
        u_if.imem_rdata <= mem_word(u_if.imem_addr);
        mem_cnt         <= 0;
      end else begin
        u_if.imem_ready <= 1'b0;
        mem_cnt         <= mem_cnt + 1;
      end
    end else begin
      u_if.imem_ready <= 1'b0;
      mem_cnt         <= 0;
    end
  end

  task automatic tick(input logic st, input logic rv, input logic [31:0] rpc);
    @(negedge clock);
    ID_Stall       = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ID_Stall = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clock);
    #1;
    n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", u_if.imem_req); end
    n_checks++; if (u_if.IF_Flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush got %b want 1", u_if.IF_Flush); end
    n_checks++; if (u_if.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", u_if.IF_Stall); end
    n_checks++; if (u_if.IF_AdEL !== 1'b0) begin n_fail++; $display("FAIL reset_adel got %b want 0", u_if.IF_AdEL); end
    n_checks++; if (u_if.PCOut !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_pc got %h want bfc00000", u_if.PCOut); end
    n_checks++; if (u_if.PCAdd4 !== 32'hBFC0_0004) begin n_fail++; $display("FAIL reset_pcadd4 got %h want bfc00004", u_if.PCAdd4); end
    ID_Stall = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp;
    mem_lat = 0;
    for (int k = 0; k < 3; k++) begin
      exp = 32'hBFC0_0000 + 32'(4 * k);
      tick(1'b0, 1'b0, '0);
      n_checks++; if (u_if.PCOut !== exp) begin n_fail++; $display("FAIL zw_pc[%0d] got %h want %h", k, u_if.PCOut, exp); end
      n_checks++; if (u_if.IF_Flush !== 1'b0) begin n_fail++; $display("FAIL zw_flush[%0d] got %b want 0", k, u_if.IF_Flush); end
      n_checks++; if (u_if.IF_Instruction !== mem_word(exp)) begin n_fail++; $display("FAIL zw_instr[%0d] got %h want %h", k, u_if.IF_Instruction, mem_word(exp)); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp;
    exp = 32'hBFC0_000C;
    mem_lat = 2;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, '0);
      n_checks++; if (u_if.PCOut !== exp) begin n_fail++; $display("FAIL lat_pc[%0d] got %h want %h", k, u_if.PCOut, exp); end
      n_checks++; if (u_if.imem_addr !== exp) begin n_fail++; $display("FAIL lat_addr[%0d] got %h want %h", k, u_if.imem_addr, exp); end
      if (k < 2) begin
        n_checks++; if (u_if.IF_Flush !== 1'b1) begin n_fail++; $display("FAIL lat_bubble[%0d] got %b want 1", k, u_if.IF_Flush); end
      end else begin
        n_checks++; if (u_if.IF_Flush !== 1'b0) begin n_fail++; $display("FAIL lat_deliver_flush got %b want 0", u_if.IF_Flush); end
        n_checks++; if (u_if.IF_Instruction !== mem_word(exp)) begin n_fail++; $display("FAIL lat_instr got %h want %h", u_if.IF_Instruction, mem_word(exp)); end
      end
    end
  endtask

  task automatic test_id_stall();
    logic [31:0] exp;
    exp = 32'hBFC0_0010;
    mem_lat = 0;
    tick(1'b1, 1'b0, '0);
    n_checks++; if (u_if.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL stall_first got %b want 1", u_if.IF_Stall); end
    n_checks++; if (u_if.IF_Instruction !== mem_word(exp)) begin n_fail++; $display("FAIL stall_first_instr got %h want %h", u_if.IF_Instruction, mem_word(exp)); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, '0);
      n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req[%0d] got %b want 0", k, u_if.imem_req); end
      n_checks++; if (u_if.IF_Instruction !== mem_word(exp)) begin n_fail++; $display("FAIL hold_instr[%0d] got %h want %h", k, u_if.IF_Instruction, mem_word(exp)); end
      n_checks++; if (u_if.PCOut !== exp) begin n_fail++; $display("FAIL hold_pc[%0d] got %h want %h", k, u_if.PCOut, exp); end
      n_checks++; if (u_if.IF_Flush !== 1'b0) begin n_fail++; $display("FAIL hold_flush[%0d] got %b want 0", k, u_if.IF_Flush); end
    end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL release_stall got %b want 0", u_if.IF_Stall); end
    n_checks++; if (u_if.IF_Instruction !== mem_word(exp)) begin n_fail++; $display("FAIL release_instr got %h want %h", u_if.IF_Instruction, mem_word(exp)); end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.PCOut !== exp + 32'd4) begin n_fail++; $display("FAIL release_pc got %h want %h", u_if.PCOut, exp + 32'd4); end
    n_checks++; if (u_if.IF_Instruction !== mem_word(exp + 32'd4)) begin n_fail++; $display("FAIL release_next_instr got %h want %h", u_if.IF_Instruction, mem_word(exp + 32'd4)); end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] old_pc;
    logic [31:0] tgt;
    logic        done;
    old_pc = 32'hBFC0_0018;
    tgt    = 32'h8000_0180;
    done   = 1'b0;
    mem_lat = 3;
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.imem_addr !== old_pc) begin n_fail++; $display("FAIL drop_pre_addr got %h want %h", u_if.imem_addr, old_pc); end
    tick(1'b0, 1'b1, tgt);
    n_checks++; if (u_if.IF_Flush !== 1'b1) begin n_fail++; $display("FAIL drop_redir_flush got %b want 1", u_if.IF_Flush); end
    for (int k = 0; k < 2; k++) begin
      tick(1'b0, 1'b0, '0);
      n_checks++; if (u_if.imem_addr !== old_pc || u_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_addr[%0d] got %h req %b want %h req 1", k, u_if.imem_addr, u_if.imem_req, old_pc); end
      n_checks++; if (u_if.IF_Flush !== 1'b1 || u_if.IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL drop_stale[%0d] flush %b instr %h want flush 1 instr 0", k, u_if.IF_Flush, u_if.IF_Instruction); end
    end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.imem_addr !== tgt || u_if.imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_new_addr got %h req %b want %h req 1", u_if.imem_addr, u_if.imem_req, tgt); end
    for (int k = 0; k < 8 && !done; k++) begin
      if (u_if.IF_Flush === 1'b0) done = 1'b1;
      else tick(1'b0, 1'b0, '0);
    end
    n_checks++; if (u_if.IF_Flush !== 1'b0) begin n_fail++; $display("FAIL drop_deliver_timeout flush got %b want 0", u_if.IF_Flush); end
    n_checks++; if (u_if.PCOut !== tgt || u_if.IF_Instruction !== mem_word(tgt)) begin n_fail++; $display("FAIL drop_deliver pc %h instr %h want pc %h instr %h", u_if.PCOut, u_if.IF_Instruction, tgt, mem_word(tgt)); end
  endtask

  task automatic test_misaligned();
    mem_lat = 0;
    tick(1'b0, 1'b1, 32'h0040_0002);
    n_checks++; if (u_if.IF_Flush !== 1'b1) begin n_fail++; $display("FAIL mis_redir_flush got %b want 1", u_if.IF_Flush); end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.IF_AdEL !== 1'b1) begin n_fail++; $display("FAIL mis_adel got %b want 1", u_if.IF_AdEL); end
    n_checks++; if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req got %b want 0", u_if.imem_req); end
    n_checks++; if (u_if.PCOut !== 32'h0040_0002) begin n_fail++; $display("FAIL mis_pc got %h want 00400002", u_if.PCOut); end
    tick(1'b1, 1'b0, '0);
    n_checks++; if (u_if.IF_AdEL !== 1'b1 || u_if.IF_Stall !== 1'b1) begin n_fail++; $display("FAIL mis_sticky adel %b stall %b want 1 1", u_if.IF_AdEL, u_if.IF_Stall); end
    tick(1'b0, 1'b1, 32'h0040_0000);
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.IF_AdEL !== 1'b0) begin n_fail++; $display("FAIL mis_recover_adel got %b want 0", u_if.IF_AdEL); end
    n_checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL mis_recover_req req %b addr %h want 1 00400000", u_if.imem_req, u_if.imem_addr); end
    n_checks++; if (u_if.IF_Instruction !== mem_word(32'h0040_0000)) begin n_fail++; $display("FAIL mis_recover_instr got %h want %h", u_if.IF_Instruction, mem_word(32'h0040_0000)); end
  endtask

  task automatic test_wrap_stall();
    mem_lat = 0;
    tick(1'b1, 1'b1, 32'hFFFF_FFFC);
    n_checks++; if (u_if.IF_Flush !== 1'b1 || u_if.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL wrap_redir flush %b stall %b want 1 0", u_if.IF_Flush, u_if.IF_Stall); end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.PCOut !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", u_if.PCOut); end
    n_checks++; if (u_if.PCAdd4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pcadd4 got %h want 00000000", u_if.PCAdd4); end
    n_checks++; if (u_if.IF_Instruction !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_instr got %h want %h", u_if.IF_Instruction, mem_word(32'hFFFF_FFFC)); end
    tick(1'b0, 1'b0, '0);
    n_checks++; if (u_if.PCOut !== 32'h0 || u_if.PCAdd4 !== 32'h4) begin n_fail++; $display("FAIL wrap_next pc %h add4 %h want 0 4", u_if.PCOut, u_if.PCAdd4); end
  endtask

  // Stream model: accepted words must follow the program-order PC sequence implied by redirects.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] rpc;
    logic        prev_pend;
    logic        st;
    logic        rv;
    int          idle;
    int          accepted;
    mem_rand = 1'b1;
    exp_pc   = 32'h1000_0000;
    tick(1'b0, 1'b1, exp_pc);
    prev_pend = u_if.imem_req && !u_if.imem_ready;
    prev_addr = u_if.imem_addr;
    idle = 0;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      tick(st, rv, rpc);
      if (prev_pend) begin
        n_checks++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable c%0d req %b addr %h want 1 %h", c, u_if.imem_req, u_if.imem_addr, prev_addr); end
      end
      if (rv) begin
        n_checks++; if (u_if.IF_Flush !== 1'b1 || u_if.IF_Stall !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect c%0d flush %b stall %b want 1 0", c, u_if.IF_Flush, u_if.IF_Stall); end
        exp_pc = rpc;
        idle = 0;
      end else begin
        n_checks++; if (u_if.IF_Stall !== st) begin n_fail++; $display("FAIL rnd_stall c%0d got %b want %b", c, u_if.IF_Stall, st); end
        if (u_if.IF_AdEL === 1'b1) begin
          n_checks++; if (u_if.PCOut !== exp_pc || exp_pc[1:0] == 2'b00 || u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_adel c%0d pc %h req %b want misaligned %h req 0", c, u_if.PCOut, u_if.imem_req, exp_pc); end
          idle = 0;
        end else if (!st && u_if.IF_Flush === 1'b0) begin
          n_checks++; if (u_if.PCOut !== exp_pc || exp_pc[1:0] != 2'b00) begin n_fail++; $display("FAIL rnd_pc c%0d got %h want aligned %h", c, u_if.PCOut, exp_pc); end
          n_checks++; if (u_if.IF_Instruction !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_instr c%0d got %h want %h", c, u_if.IF_Instruction, mem_word(exp_pc)); end
          n_checks++; if (u_if.PCAdd4 !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pcadd4 c%0d got %h want %h", c, u_if.PCAdd4, exp_pc + 32'd4); end
          exp_pc = exp_pc + 32'd4;
          idle = 0;
          accepted++;
        end else begin
          if (!st) begin
            n_checks++; if (u_if.IF_Instruction !== 32'h0) begin n_fail++; $display("FAIL rnd_bubble_instr c%0d got %h want 0", c, u_if.IF_Instruction); end
          end
          idle++;
          if (idle > 64) begin
            n_checks++; n_fail++;
            $display("FAIL rnd_progress c%0d no delivery for %0d cycles, want <= 64", c, idle);
            idle = 0;
          end
        end
      end
      prev_pend = u_if.imem_req && !u_if.imem_ready;
      prev_addr = u_if.imem_addr;
    end
    n_checks++; if (accepted < 100) begin n_fail++; $display("FAIL rnd_throughput got %0d accepted want >= 100", accepted); end
    mem_rand = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_id_stall();
    test_redirect_drop();
    test_misaligned();
    test_wrap_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
